// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB with a 2-bit saturating counter per entry.
// Lookup is combinational on pcF; decode-stage resolution updates the table and the statistics counters.
module branch_predictor #(
    parameter int IDX_W = 4,
    parameter int TAG_W = 30 - IDX_W
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] pcF,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_npc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_npc,
    input  logic        flush_all,
    output logic        mispredict,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);

    localparam int ENTRIES = 1 << IDX_W;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         cnt_q    [ENTRIES];

    logic [31:0] branch_cnt_q;
    logic [31:0] mispred_cnt_q;

    logic [IDX_W-1:0] idx_f;
    logic [TAG_W-1:0] tag_f;
    logic [IDX_W-1:0] idx_u;
    logic [TAG_W-1:0] tag_u;
    logic             upd_hit;
    logic [1:0]       cnt_u;
    logic [1:0]       cnt_d;

    // Word-offset bits of both PCs are never looked at.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pcF[1:0], upd_pc[1:0]};

    assign idx_f = pcF[IDX_W+1:2];
    assign tag_f = pcF[31:IDX_W+2];
    assign idx_u = upd_pc[IDX_W+1:2];
    assign tag_u = upd_pc[31:IDX_W+2];

    // Lookup always sees the pre-update table; no write bypass.
    assign pred_hit   = valid_q[idx_f] & (tag_q[idx_f] == tag_f);
    assign pred_taken = pred_hit & cnt_q[idx_f][1];
    assign pred_npc   = pred_taken ? target_q[idx_f] : (pcF + 32'd4);

    assign mispredict = upd_valid &
                        ((upd_pred_taken != upd_taken) |
                         (upd_taken & (upd_pred_npc != upd_target)));

    assign upd_hit = valid_q[idx_u] & (tag_q[idx_u] == tag_u);
    assign cnt_u   = cnt_q[idx_u];

    always_comb begin
        cnt_d = cnt_u;
        if (upd_taken) begin
            if (cnt_u != 2'b11) cnt_d = cnt_u + 2'd1;
        end else begin
            if (cnt_u != 2'b00) cnt_d = cnt_u - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= 2'b01;
            end
        end else if (flush_all) begin
            // Flush wins over a same-cycle update; tag/target/cnt are left stale.
            valid_q <= '0;
        end else if (upd_valid) begin
            if (upd_hit) begin
                cnt_q[idx_u] <= cnt_d;
                if (upd_taken) target_q[idx_u] <= upd_target;
            end else if (upd_taken) begin
                valid_q[idx_u]  <= 1'b1;
                tag_q[idx_u]    <= tag_u;
                target_q[idx_u] <= upd_target;
                cnt_q[idx_u]    <= 2'b10;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else if (upd_valid) begin
            branch_cnt_q  <= branch_cnt_q + 32'd1;
            mispred_cnt_q <= mispred_cnt_q + {31'd0, mispredict};
        end
    end

    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: lookup, allocation, saturation, aliasing, flush and async reset.
module tb_branch_predictor;

    logic        clk;
    logic        resetn;
    logic [31:0] pcF;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_npc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_npc;
    logic        flush_all;
    logic        mispredict;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    int checks = 0;
    int errors = 0;

    branch_predictor #(.IDX_W(4)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .pcF            (pcF),
        .pred_hit       (pred_hit),
        .pred_taken     (pred_taken),
        .pred_npc       (pred_npc),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_pred_taken (upd_pred_taken),
        .upd_pred_npc   (upd_pred_npc),
        .flush_all      (flush_all),
        .mispredict     (mispredict),
        .branch_cnt     (branch_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                        input logic tkn, input logic [31:0] npc);
        @(negedge clk);
        pcF = pc;
        #1;
        chk({tag, ".hit"},   {31'd0, pred_hit},   {31'd0, hit});
        chk({tag, ".taken"}, {31'd0, pred_taken}, {31'd0, tkn});
        chk({tag, ".npc"},   pred_npc,            npc);
    endtask

    task automatic cnts(input string tag, input logic [31:0] br, input logic [31:0] mp);
        chk({tag, ".branch_cnt"},  branch_cnt,  br);
        chk({tag, ".mispred_cnt"}, mispred_cnt, mp);
    endtask

    task automatic drive_upd(input logic [31:0] pc, input logic tkn, input logic [31:0] tgt,
                             input logic ptkn, input logic [31:0] pnpc, input logic flush);
        upd_valid      = 1'b1;
        upd_pc         = pc;
        upd_taken      = tkn;
        upd_target     = tgt;
        upd_pred_taken = ptkn;
        upd_pred_npc   = pnpc;
        flush_all      = flush;
    endtask

    task automatic idle_upd();
        upd_valid = 1'b0;
        flush_all = 1'b0;
    endtask

    task automatic do_upd(input string tag, input logic [31:0] pc, input logic tkn,
                          input logic [31:0] tgt, input logic ptkn, input logic [31:0] pnpc,
                          input logic exp_mp);
        @(negedge clk);
        drive_upd(pc, tkn, tgt, ptkn, pnpc, 1'b0);
        #1;
        chk({tag, ".mispredict"}, {31'd0, mispredict}, {31'd0, exp_mp});
        @(posedge clk);
        #1;
        idle_upd();
    endtask

    initial begin
        resetn = 1'b0;
        pcF = 32'hBFC0_0000;
        idle_upd();
        upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        upd_pred_taken = 1'b0; upd_pred_npc = '0;

        // 1: reset state
        #2;
        chk("rst.hit",   {31'd0, pred_hit},   32'd0);
        chk("rst.taken", {31'd0, pred_taken}, 32'd0);
        chk("rst.npc",   pred_npc,            32'hBFC0_0004);
        chk("rst.mp",    {31'd0, mispredict}, 32'd0);
        cnts("rst", 32'd0, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        look("rst_lookup", 32'h8000_0010, 1'b0, 1'b0, 32'h8000_0014);

        // 2: allocate, with lookup of the same PC in the update cycle
        @(negedge clk);
        pcF = 32'h8000_0010;
        drive_upd(32'h8000_0010, 1'b1, 32'h8000_0100, 1'b0, 32'h8000_0014, 1'b0);
        #1;
        chk("alloc.mispredict", {31'd0, mispredict}, 32'd1);
        chk("alloc.same_cycle_hit", {31'd0, pred_hit}, 32'd0);
        @(posedge clk);
        #1;
        idle_upd();
        look("alloc", 32'h8000_0010, 1'b1, 1'b1, 32'h8000_0100);
        cnts("alloc", 32'd1, 32'd1);

        // 3: saturation; cnt 10 -> 11 -> 11 -> 11
        for (int i = 0; i < 3; i++)
            do_upd("sat_t", 32'h8000_0010, 1'b1, 32'h8000_0100, 1'b1, 32'h8000_0100, 1'b0);
        cnts("sat_t", 32'd4, 32'd1);
        do_upd("sat_nt1", 32'h8000_0010, 1'b0, 32'h8000_0100, 1'b1, 32'h8000_0100, 1'b1);
        look("cnt10", 32'h8000_0010, 1'b1, 1'b1, 32'h8000_0100);
        do_upd("sat_nt2", 32'h8000_0010, 1'b0, 32'h8000_0100, 1'b1, 32'h8000_0100, 1'b1);
        look("cnt01", 32'h8000_0010, 1'b1, 1'b0, 32'h8000_0014);
        do_upd("sat_nt3", 32'h8000_0010, 1'b0, 32'h8000_0100, 1'b0, 32'h8000_0014, 1'b0);
        look("cnt00", 32'h8000_0010, 1'b1, 1'b0, 32'h8000_0014);
        do_upd("sat_nt4", 32'h8000_0010, 1'b0, 32'h8000_0100, 1'b0, 32'h8000_0014, 1'b0);
        look("cnt00_sat", 32'h8000_0010, 1'b1, 1'b0, 32'h8000_0014);
        cnts("sat_nt", 32'd8, 32'd3);
        do_upd("up1", 32'h8000_0010, 1'b1, 32'h8000_0100, 1'b0, 32'h8000_0014, 1'b1);
        look("cnt01_up", 32'h8000_0010, 1'b1, 1'b0, 32'h8000_0014);
        do_upd("up2", 32'h8000_0010, 1'b1, 32'h8000_0100, 1'b0, 32'h8000_0014, 1'b1);
        look("cnt10_up", 32'h8000_0010, 1'b1, 1'b1, 32'h8000_0100);
        // taken hit with a new target: target rewritten, wrong-target counts as mispredict
        do_upd("retarget", 32'h8000_0010, 1'b1, 32'h8000_0200, 1'b1, 32'h8000_0100, 1'b1);
        look("retarget", 32'h8000_0010, 1'b1, 1'b1, 32'h8000_0200);
        cnts("retarget", 32'd11, 32'd6);

        // 4: aliasing on index 4
        look("alias_miss", 32'h8000_0410, 1'b0, 1'b0, 32'h8000_0414);
        do_upd("alias_alloc", 32'h8000_0410, 1'b1, 32'h8000_0800, 1'b0, 32'h8000_0414, 1'b1);
        look("alias_new", 32'h8000_0410, 1'b1, 1'b1, 32'h8000_0800);
        look("alias_old", 32'h8000_0010, 1'b0, 1'b0, 32'h8000_0014);
        do_upd("nt_miss", 32'h8000_0030, 1'b0, 32'h8000_0900, 1'b0, 32'h8000_0034, 1'b0);
        look("nt_miss", 32'h8000_0030, 1'b0, 1'b0, 32'h8000_0034);
        cnts("alias", 32'd13, 32'd7);

        // 5: same-cycle hazard on 0x80000020, then flush racing an update
        @(negedge clk);
        pcF = 32'h8000_0020;
        drive_upd(32'h8000_0020, 1'b1, 32'h8000_0040, 1'b0, 32'h8000_0024, 1'b0);
        #1;
        chk("hazard.same_cycle_hit", {31'd0, pred_hit}, 32'd0);
        chk("hazard.same_cycle_npc", pred_npc, 32'h8000_0024);
        @(posedge clk);
        #1;
        idle_upd();
        chk("hazard.next_cycle_hit", {31'd0, pred_hit}, 32'd1);
        chk("hazard.next_cycle_npc", pred_npc, 32'h8000_0040);
        @(negedge clk);
        drive_upd(32'h8000_0050, 1'b1, 32'h8000_0060, 1'b0, 32'h8000_0054, 1'b1);
        @(posedge clk);
        #1;
        idle_upd();
        look("flush_a", 32'h8000_0020, 1'b0, 1'b0, 32'h8000_0024);
        look("flush_b", 32'h8000_0410, 1'b0, 1'b0, 32'h8000_0414);
        look("flush_dropped", 32'h8000_0050, 1'b0, 1'b0, 32'h8000_0054);
        cnts("flush", 32'd15, 32'd9);

        // 6: async reset mid-stream
        do_upd("repop", 32'h8000_0020, 1'b1, 32'h8000_0040, 1'b0, 32'h8000_0024, 1'b1);
        look("repop", 32'h8000_0020, 1'b1, 1'b1, 32'h8000_0040);
        cnts("repop", 32'd16, 32'd10);
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst.hit_populated", {31'd0, pred_hit}, 32'd0);
        cnts("arst", 32'd0, 32'd0);
        pcF = 32'hBFC0_0000;
        #1;
        chk("arst.hit",   {31'd0, pred_hit},   32'd0);
        chk("arst.taken", {31'd0, pred_taken}, 32'd0);
        chk("arst.npc",   pred_npc,            32'hBFC0_0004);
        @(negedge clk);
        resetn = 1'b1;

        // correctly predicted branches leave mispred_cnt alone
        do_upd("good_t", 32'h8000_0060, 1'b1, 32'h8000_0100, 1'b1, 32'h8000_0100, 1'b0);
        do_upd("good_nt", 32'h8000_0070, 1'b0, 32'h8000_0200, 1'b0, 32'h8000_0074, 1'b0);
        look("post_rst_alloc", 32'h8000_0060, 1'b1, 1'b1, 32'h8000_0100);
        cnts("post_rst", 32'd2, 32'd0);

        // upd_valid low: mispredict masked, nothing counted
        @(negedge clk);
        upd_valid = 1'b0;
        upd_taken = 1'b1;
        upd_pred_taken = 1'b0;
        #1;
        chk("idle.mispredict", {31'd0, mispredict}, 32'd0);
        @(posedge clk);
        #1;
        cnts("idle", 32'd2, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Fetch-stage branch predictor with a direct-mapped branch target buffer and 2-bit saturating counters.
- Predicts next PC at fetch; decode-stage branch resolution (equality/sign compare result) feeds back actual outcome and target.
- Flags mispredictions and keeps running statistics.
- Sits between PC mux (fetch) and decode branch-resolve logic.

Parameters:
IDX_W, 4, index width; table has 2**IDX_W entries
TAG_W, 30-IDX_W, tag width = PC[31:IDX_W+2]

Ports:
clk  in  1  clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
pcF  in  32  fetch PC (word aligned)
pred_hit  out  1  BTB entry valid and tag matches pcF
pred_taken  out  1  predicted taken
pred_npc  out  32  predicted next PC
upd_valid  in  1  decode resolved a branch this cycle
upd_pc  in  32  PC of resolved branch
upd_taken  in  1  actual outcome
upd_target  in  32  actual taken target
upd_pred_taken  in  1  prediction carried down pipe for this branch
upd_pred_npc  in  32  predicted next PC carried down pipe
flush_all  in  1  synchronous invalidate of whole table
mispredict  out  1  resolved branch was mispredicted (combinational)
branch_cnt  out  32  number of resolved branches
mispred_cnt  out  32  number of mispredictions

Behaviour:
- Entry fields: valid (1), tag (TAG_W), target (32), cnt (2).
- Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2].
- Reset (resetn low, async): every valid=0, cnt=2'b01, tag=0, target=0; branch_cnt=0, mispred_cnt=0. Outputs at reset: pred_hit=0, pred_taken=0, pred_npc=pcF+4, mispredict=0.
- Lookup is combinational, zero latency:
  - pred_hit = valid[idx] & (tag[idx]==tagF).
  - pred_taken = pred_hit & cnt[idx][1].
  - pred_npc = pred_taken ? target[idx] : pcF+4, with 32-bit wrap.
- mispredict = upd_valid & ((upd_pred_taken != upd_taken) | (upd_taken & (upd_pred_npc != upd_target))).
- Update, on a clock edge with upd_valid=1:
  - Hit (valid & tag match at upd index):
    - cnt saturating: taken: 00→01→10→11→11; not taken: 11→10→01→00→00.
    - If taken, target <= upd_target.
    - tag and valid unchanged.
  - Miss and upd_taken=1: allocate (overwrite any entry): valid=1, tag=upd tag, target=upd_target, cnt=2'b10.
  - Miss and upd_taken=0: no table change.
  - branch_cnt += 1; mispred_cnt += mispredict. Both wrap at 2**32.
- Simultaneous lookup and update on same index: lookup returns pre-update contents. No bypass; new state visible the cycle after the edge.
- flush_all=1 on an edge clears all valid bits.
  - cnt/target/tag are kept but unused.
  - flush_all has priority over an update in the same cycle: the table write is dropped, but the statistics counters still update.
- resetn asserted mid-operation clears immediately regardless of clk. First update after release behaves as from reset.
- No handshake or backpressure: every upd_valid cycle is consumed. upd_valid=0 changes nothing.

Test Plan:
1. Reset, pcF=0xBFC00000 → pred_hit=0, pred_taken=0, pred_npc=0xBFC00004; branch_cnt=0, mispred_cnt=0.
2. Allocate: upd_valid, upd_pc=0x80000010, taken, target=0x80000100, pred_taken=0, pred_npc=0x80000014 → mispredict=1. Next cycle: pcF=0x80000010 gives pred_hit=1, pred_taken=1 (cnt=10), pred_npc=0x80000100; mispred_cnt=1, branch_cnt=1.
3. Saturation on 0x80000010:
   - Three taken updates → cnt=11.
   - Two not-taken updates → cnt=01, pred_taken=0, pred_npc=0x80000014.
   - Two more not-taken → cnt stays 00.
4. Aliasing: after test 2, lookup pcF=0x80000410 (same index 4, different tag) → pred_hit=0. Taken update from 0x80000410 replaces the entry; 0x80000010 then misses.
5. Same-cycle hazard: pcF=upd_pc=0x80000020 on first allocate edge → pred_hit=0 that cycle, 1 next cycle. flush_all with upd_valid in the same cycle → all pred_hit=0, branch_cnt still increments.
6. Async reset pulse mid-stream with table populated and counters nonzero → outputs return to test 1 values without a clock edge. mispred_cnt stays 0 for a correctly predicted branch (upd_pred_taken=1, upd_pred_npc=upd_target).
